// File: rtl/can_clic_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : can_clic_ctrl_pkg
// Purpose  : Shared types and constants for the CLIC interrupt controller:
//            default line count / priority width, the priority and index
//            types, the packed per-line entry array and the controller state.
// Revision : 1.0 - initial release
// ============================================================================
package can_clic_ctrl_pkg;

    localparam int N_IRQ  = 4;
    localparam int PRIO_W = 3;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef logic [PRIO_W-1:0]       Prio;
    typedef logic [IDX_W-1:0]        Index;
    typedef Prio [N_IRQ-1:0]         Entries;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } CtrlState;

endpackage : can_clic_ctrl_pkg
`default_nettype wire

// File: rtl/can_clic_arb.sv
`default_nettype none
// ============================================================================
// Module   : can_clic_arb
// Purpose  : Combinational maximum-priority finder. An entry of 0 never
//            wins; ties resolve to the lowest line index.
// Ports    : i_entries      per-line effective priority (0 = not requesting)
//            o_is_interrupt winner priority is nonzero
//            o_index        winning line
//            o_prio         winning priority
// Revision : 1.0 - initial release
// ============================================================================
module can_clic_arb #(
    parameter int N_IRQ  = 4,
    parameter int PRIO_W = 3,
    parameter int ID_W   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0][PRIO_W-1:0] i_entries,
    output logic                         o_is_interrupt,
    output logic [ID_W-1:0]              o_index,
    output logic [PRIO_W-1:0]            o_prio
);

    logic [PRIO_W-1:0] w_best;
    logic [ID_W-1:0]   w_idx;

    // Strict '>' while scanning upward keeps the lowest index on ties.
    always_comb begin
        w_best = '0;
        w_idx  = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (i_entries[i] > w_best) begin
                w_best = i_entries[i];
                w_idx  = ID_W'(i);
            end
        end
    end

    assign o_is_interrupt = (w_best != '0);
    assign o_index        = w_idx;
    assign o_prio         = w_best;

endmodule : can_clic_arb
`default_nettype wire

// File: rtl/can_clic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : can_clic_ctrl
// Purpose  : Sequential CLIC controller. Keeps per-line pending/enable/
//            priority state and a running threshold, raises one request at a
//            time to the core via req/ack, and nests handler levels on a
//            threshold stack (ack pushes, done_i pops).
// Ports    : clk, reset (sync, active high)
//            irq_i                       per-line set pulses
//            cfg_we_i/idx/prio/en        per-line configuration write
//            irq_req_o/id_o/prio_o       request to core, held until ack
//            irq_ack_i                   core accepts request
//            done_i                      handler return
//            level_o                     current threshold
//            err_o                       sticky error (CAN_CLIC_ERR_EN only)
// Config   : define CAN_CLIC_ERR_EN to add err_o (pop on empty stack, or an
//            eligible interrupt blocked by a full stack).
// Revision : 1.0 - initial release
// ============================================================================
module can_clic_ctrl #(
    parameter int N_IRQ  = can_clic_ctrl_pkg::N_IRQ,
    parameter int PRIO_W = can_clic_ctrl_pkg::PRIO_W,
    parameter int DEPTH  = can_clic_ctrl_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_IRQ-1:0]           irq_i,
    input  logic                       cfg_we_i,
    input  logic [$clog2(N_IRQ)-1:0]   cfg_idx_i,
    input  logic [PRIO_W-1:0]          cfg_prio_i,
    input  logic                       cfg_en_i,
    output logic                       irq_req_o,
    output logic [$clog2(N_IRQ)-1:0]   irq_id_o,
    output logic [PRIO_W-1:0]          irq_prio_o,
    input  logic                       irq_ack_i,
    input  logic                       done_i,
`ifdef CAN_CLIC_ERR_EN
    output logic                       err_o,
`endif
    output logic [PRIO_W-1:0]          level_o
);

    import can_clic_ctrl_pkg::*;

    localparam int ID_W  = $clog2(N_IRQ);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0]       c_idle = IDLE;
    localparam logic [0:0]       c_req  = REQ;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [0:0]                   r_state;
    logic [N_IRQ-1:0]             r_pend;
    logic [N_IRQ-1:0]             r_en;
    logic [N_IRQ-1:0][PRIO_W-1:0] r_prio;
    logic [PRIO_W-1:0]            r_thr;
    logic [PRIO_W-1:0]            r_stack [DEPTH];
    logic [CNT_W-1:0]             r_cnt;
    logic [ID_W-1:0]              r_id;
    logic [PRIO_W-1:0]            r_oprio;

    logic [N_IRQ-1:0][PRIO_W-1:0] w_entries;
    logic                         w_is_int;
    logic [ID_W-1:0]              w_win_idx;
    logic [PRIO_W-1:0]            w_win_prio;
    logic                         w_ack;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_eligible;
    logic [N_IRQ-1:0]             w_pend_nxt;
    logic [SP_W-1:0]              w_wr_ptr;
    logic [SP_W-1:0]              w_rd_ptr;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_entries
        assign w_entries[g] = (r_pend[g] && r_en[g]) ? r_prio[g] : '0;
    end

    can_clic_arb #(
        .N_IRQ  (N_IRQ),
        .PRIO_W (PRIO_W),
        .ID_W   (ID_W)
    ) u_arb (
        .i_entries      (w_entries),
        .o_is_interrupt (w_is_int),
        .o_index        (w_win_idx),
        .o_prio         (w_win_prio)
    );

    assign w_ack      = (r_state == c_req) && irq_ack_i;
    assign w_pop      = done_i && (r_cnt != '0);
    assign w_full     = (r_cnt == c_full);
    assign w_eligible = (r_state == c_idle) && w_is_int && (w_win_prio > r_thr);

    // Push only happens below full and pop only above empty, so the low
    // bits of the count always address a valid slot.
    assign w_wr_ptr = r_cnt[SP_W-1:0];
    assign w_rd_ptr = SP_W'(r_cnt - 1'b1);

    // A new set pulse wins over the ack-driven clear on the same line.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_ack) begin
            w_pend_nxt[r_id] = 1'b0;
        end
        w_pend_nxt = w_pend_nxt | irq_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_pend  <= '0;
            r_en    <= '0;
            r_prio  <= '0;
            r_thr   <= '0;
            r_cnt   <= '0;
            r_id    <= '0;
            r_oprio <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_pend <= w_pend_nxt;

            if (cfg_we_i) begin
                r_prio[cfg_idx_i] <= cfg_prio_i;
                r_en[cfg_idx_i]   <= cfg_en_i;
            end

            // Simultaneous done+ack: the popped level would be pushed right
            // back, so the stack is left untouched and only the level moves.
            if (w_ack && w_pop) begin
                r_thr <= r_oprio;
            end else if (w_ack) begin
                r_stack[w_wr_ptr] <= r_thr;
                r_cnt             <= r_cnt + 1'b1;
                r_thr             <= r_oprio;
            end else if (w_pop) begin
                r_thr <= r_stack[w_rd_ptr];
                r_cnt <= r_cnt - 1'b1;
            end

            case (r_state)
                c_idle: begin
                    if (w_eligible && !w_full) begin
                        r_state <= c_req;
                        r_id    <= w_win_idx;
                        r_oprio <= w_win_prio;
                    end
                end
                c_req: begin
                    if (irq_ack_i) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

`ifdef CAN_CLIC_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((done_i && (r_cnt == '0)) || (w_eligible && w_full)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

    assign irq_req_o  = (r_state == c_req);
    assign irq_id_o   = r_id;
    assign irq_prio_o = r_oprio;
    assign level_o    = r_thr;

endmodule : can_clic_ctrl
`default_nettype wire

// File: tb/tb_can_clic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_clic_ctrl
// Purpose  : Self-checking bench for can_clic_ctrl. A behavioural model
//            (arrays plus a queue for the nesting stack) predicts the outputs
//            every cycle; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_clic_ctrl;

    localparam int N  = 4;
    localparam int PW = 3;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_i;
    logic          cfg_we_i;
    logic [1:0]    cfg_idx_i;
    logic [PW-1:0] cfg_prio_i;
    logic          cfg_en_i;
    logic          irq_req_o;
    logic [1:0]    irq_id_o;
    logic [PW-1:0] irq_prio_o;
    logic          irq_ack_i;
    logic          done_i;
    logic [PW-1:0] level_o;
`ifdef CAN_CLIC_ERR_EN
    logic          err_o;
`endif

    always #5 clk = ~clk;

    can_clic_ctrl #(.N_IRQ(N), .PRIO_W(PW), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_i      (irq_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_idx_i  (cfg_idx_i),
        .cfg_prio_i (cfg_prio_i),
        .cfg_en_i   (cfg_en_i),
        .irq_req_o  (irq_req_o),
        .irq_id_o   (irq_id_o),
        .irq_prio_o (irq_prio_o),
        .irq_ack_i  (irq_ack_i),
        .done_i     (done_i),
`ifdef CAN_CLIC_ERR_EN
        .err_o      (err_o),
`endif
        .level_o    (level_o)
    );

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model state
    int m_pend [N];
    int m_en   [N];
    int m_prio [N];
    int m_thr;
    int m_req;
    int m_id;
    int m_rprio;
    int m_err;
    int m_stack [$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge of the model, using the inputs as sampled at that edge.
    task automatic model_step();
        int wi, wp, e, full, elig, ack, pop;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_en[i] = 0; m_prio[i] = 0;
            end
            m_thr = 0; m_req = 0; m_id = 0; m_rprio = 0; m_err = 0;
            m_stack.delete();
            return;
        end
        // Scan from the top with >= so the lowest index survives a tie.
        wi = 0; wp = 0;
        for (int i = N - 1; i >= 0; i--) begin
            e = (m_pend[i] != 0 && m_en[i] != 0) ? m_prio[i] : 0;
            if (e != 0 && e >= wp) begin
                wp = e; wi = i;
            end
        end
        full = (m_stack.size() == D);
        elig = (m_req == 0) && (wp > m_thr);
        ack  = (m_req != 0) && irq_ack_i;
        pop  = done_i && (m_stack.size() > 0);
        if ((done_i && m_stack.size() == 0) || (elig && full)) m_err = 1;
        if (ack) m_pend[m_id] = 0;
        for (int i = 0; i < N; i++) if (irq_i[i]) m_pend[i] = 1;
        if (ack && pop) begin
            m_thr = m_rprio;
        end else if (ack) begin
            m_stack.push_back(m_thr);
            m_thr = m_rprio;
        end else if (pop) begin
            m_thr = m_stack.pop_back();
        end
        if (m_req != 0) begin
            if (ack) m_req = 0;
        end else if (elig && !full) begin
            m_req = 1; m_id = wi; m_rprio = wp;
        end
        if (cfg_we_i) begin
            m_prio[cfg_idx_i] = cfg_prio_i;
            m_en[cfg_idx_i]   = cfg_en_i;
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_req", irq_req_o, m_req);
        if (m_req != 0) begin
            chk("model_id", irq_id_o, m_id);
            chk("model_prio", irq_prio_o, m_rprio);
        end
        chk("model_level", level_o, m_thr);
`ifdef CAN_CLIC_ERR_EN
        chk("model_err", err_o, m_err);
`endif
    endtask

    task automatic cfg(input int idx, input int p, input int en);
        cfg_we_i = 1'b1; cfg_idx_i = 2'(idx); cfg_prio_i = PW'(p); cfg_en_i = 1'(en);
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq_i = m;
        tick();
        irq_i = '0;
    endtask

    task automatic ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    task automatic done();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!irq_req_o && n < 10) begin
            tick();
            n++;
        end
        chk("wait_req_timeout", irq_req_o, 1);
    endtask

    task automatic lit_req(input string name, input int id, input int p);
        chk({name, "_req"}, irq_req_o, 1);
        chk({name, "_id"}, irq_id_o, id);
        chk({name, "_prio"}, irq_prio_o, p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; irq_i = '0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_prio_i = '0;
        cfg_en_i = 1'b0; irq_ack_i = 1'b0; done_i = 1'b0;
        tick(); tick();
        chk("rst_req", irq_req_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_id", irq_id_o, 0);
        chk("rst_prio", irq_prio_o, 0);
        reset = 1'b0;

        // Basic arbitration, preemption and unwinding
        cfg(0, 3, 1); cfg(1, 1, 1); cfg(2, 2, 1); cfg(3, 5, 1);
        pulse(4'b0110);
        chk("lat_no_req_yet", irq_req_o, 0);
        tick();
        lit_req("s1_first", 2, 2);
        ack();
        chk("s1_level2", level_o, 2);
        pulse(4'b1000);
        tick();
        lit_req("s1_preempt", 3, 5);
        ack();
        chk("s1_level5", level_o, 5);
        done();
        chk("s1_pop2", level_o, 2);
        done();
        chk("s1_pop0", level_o, 0);
        wait_req();
        lit_req("s1_left", 1, 1);
        ack(); done();

        // Tie goes to the lowest index; the equal-priority line waits for done
        cfg(1, 3, 1); cfg(2, 3, 1);
        pulse(4'b0110);
        tick();
        lit_req("s2_tie", 1, 3);
        ack();
        chk("s2_level3", level_o, 3);
        tick(); tick();
        chk("s2_blocked", irq_req_o, 0);
        done();
        tick();
        lit_req("s2_after_done", 2, 3);
        ack(); done();

        // Request held stable while unacked, despite a higher line and cfg write
        cfg(0, 1, 1);
        pulse(4'b0001);
        tick();
        lit_req("s3_low", 0, 1);
        pulse(4'b1000);
        cfg(0, 7, 1);
        tick();
        lit_req("s3_held", 0, 1);
        ack();
        chk("s3_level1", level_o, 1);
        tick();
        lit_req("s3_high", 3, 5);
        ack(); done(); done();
        chk("s3_unwound", level_o, 0);
        cfg(0, 1, 1);

        // Fill the stack to DEPTH, then a higher interrupt must wait
        cfg(1, 2, 1); cfg(2, 3, 1); cfg(3, 4, 1);
        for (int i = 0; i < N; i++) begin
            pulse(4'(1 << i));
            wait_req();
            chk("s4_nest_id", irq_id_o, i);
            ack();
        end
        chk("s4_level4", level_o, 4);
        cfg(0, 5, 1);
        pulse(4'b0001);
        tick(); tick();
        chk("s4_full_noreq", irq_req_o, 0);
`ifdef CAN_CLIC_ERR_EN
        chk("s4_err", err_o, 1);
`endif
        done();
        chk("s4_pop3", level_o, 3);
        tick();
        lit_req("s4_after_pop", 0, 5);
        ack();
        chk("s4_level5", level_o, 5);
        done(); done(); done(); done();
        chk("s4_unwound", level_o, 0);
        done();
        chk("s4_empty_pop", level_o, 0);

        // done and ack in the same cycle
        cfg(3, 7, 1);
        pulse(4'b0001);
        wait_req();
        ack();
        chk("s5_level5", level_o, 5);
        pulse(4'b1000);
        wait_req();
        chk("s5_id", irq_id_o, 3);
        done_i = 1'b1; irq_ack_i = 1'b1;
        tick();
        done_i = 1'b0; irq_ack_i = 1'b0;
        chk("s5_swap_level", level_o, 7);
        done();
        chk("s5_restore", level_o, 0);

        // Set/clear collision, then reset mid-request
        cfg(1, 2, 1);
        pulse(4'b0010);
        wait_req();
        chk("s6_id", irq_id_o, 1);
        irq_i = 4'b0010;
        ack();
        irq_i = '0;
        chk("s6_level2", level_o, 2);
        tick(); tick();
        chk("s6_no_req", irq_req_o, 0);
        done();
        tick();
        lit_req("s6_repend", 1, 2);
        reset = 1'b1;
        tick();
        chk("s6_rst_req", irq_req_o, 0);
        chk("s6_rst_level", level_o, 0);
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        chk("s6_quiet", irq_req_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_can_clic_ctrl
`default_nettype wire
